// File: rtl/exp_sum_accum.sv
// Softmax exponent-sum stage: sums N unsigned beats with 32-bit saturation,
// then holds the sum until the downstream pipeline register loads it.
module exp_sum_accum #(
    parameter int unsigned N = 8,
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         sum_valid,
    input  logic         sum_ready,
    output logic [W-1:0] sum_data,
    output logic         sum_sat,
    output logic         sum_load
);

    localparam int unsigned CW = $clog2(N + 1) + 1;

    localparam logic [0:0] ACCUM = 1'b0;
    localparam logic [0:0] HOLD  = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [W-1:0]  acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sat_q, sat_d;
    logic [W:0]    sum_w;

    assign sum_w = {1'b0, acc_q} + {1'b0, in_data};

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
        end
    end

    // Next state; clr outranks both the input accept and the output handshake
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        if (clr) begin
            state_d = ACCUM;
            acc_d   = '0;
            cnt_d   = '0;
            sat_d   = 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (in_valid) begin
                        acc_d = sum_w[W] ? {W{1'b1}} : sum_w[W-1:0];
                        sat_d = sat_q | sum_w[W];
                        cnt_d = cnt_q + CW'(1);
                        if (cnt_q == CW'(N - 1)) begin
                            state_d = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (sum_ready) begin
                        state_d = ACCUM;
                        acc_d   = '0;
                        cnt_d   = '0;
                        sat_d   = 1'b0;
                    end
                end
                default: state_d = ACCUM;
            endcase
        end
    end

    assign in_ready  = (state_q == ACCUM);
    assign sum_valid = (state_q == HOLD);
    assign sum_data  = acc_q;
    assign sum_sat   = sat_q;
    // Asserted even under clr so a pending sum is still delivered
    assign sum_load  = sum_valid & sum_ready;

endmodule
